cache_mem_arbiter: RTL
======================

# cache_mem_arbiter

Arbitrates between the instruction cache and the data cache for the single-ported RAM. It sits directly downstream of the dcache and icache and drives the RAM request port. It serialises word accesses, returns RAM data and per-requestor wait handshakes, and prioritises dcache traffic with an optional anti-starvation guard for icache fetches.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive dcache grants allowed while icache is pending before icache is forced (guard build only); range 1–15.
- RAM_W, 32: address/data width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  RAM_W  icache word address.
- iwait  out  1  0 only in the cycle icache data is valid.
- iload  out  RAM_W  icache read data (= ramload).
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  RAM_W  dcache word address.
- dstore  in  RAM_W  dcache write data.
- dwait  out  1  0 only in the cycle the dcache access completes.
- dload  out  RAM_W  dcache read data (= ramload).
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  RAM_W  RAM address.
- ramstore  out  RAM_W  RAM write data.
- ramload  in  RAM_W  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- ram_err  out  1  sticky; set on any ERROR seen during a grant.

## Operation
- States: IDLE, DGRANT, IGRANT.
- IDLE: no RAM strobes; iwait=dwait=1. At the clock edge, arbitrate: dreq=dREN|dWEN.
  - dreq only -> DGRANT; iREN only -> IGRANT; neither -> IDLE.
  - Both: DGRANT, unless the guard is built in and dstreak==STARVE_MAX, in which case IGRANT.
- DGRANT: ramaddr=daddr. If dWEN=1: ramWEN=1, ramstore=dstore, ramREN=0. dWEN wins over dREN. Otherwise ramREN=1.
- IGRANT: ramREN=1, ramaddr=iaddr, ramstore=0.
- Completion: in a grant state with ramstate==ACCESS, drive the granted wait low for that cycle and go to IDLE next edge.
  - The other wait stays 1.
  - Each access is exactly one word.
- Requestor drops its request while granted (e.g. dREN and dWEN both 0 in DGRANT): strobes go to 0 that cycle, wait stays 1, return to IDLE next edge.
- ERROR in a grant state: wait stays 1, strobes held, state held (retry); ram_err set and held until reset.
- BUSY or FREE in a grant state: hold state and strobes; wait=1.
- Data outputs iload and dload are continuous copies of ramload. They are qualified only by the wait low.

## Timing
- Reset values: state IDLE, iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, ram_err=0, dstreak=0.
- Reset asserted mid-grant aborts immediately: strobes drop asynchronously and no wait pulse is produced.
- Arbitration latency: request seen in IDLE at edge N -> strobes asserted from cycle N+1.
- Minimum access: 2 cycles (1 IDLE + 1 grant with ACCESS). Every access is followed by at least 1 IDLE cycle, so back-to-back requests complete every 2 cycles with zero RAM latency.
- Wait pulse width: exactly 1 cycle per completed access.
- Strobes and address are combinational from state and the granted requestor's inputs; they must be stable for the whole grant.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A 4-bit dstreak counter increments on every DGRANT entry made while iREN=1, saturating at STARVE_MAX.
  - The counter clears on IGRANT entry or when iREN=0 at arbitration.
  - When the counter equals STARVE_MAX and both requests are present, icache is granted.
- Not defined: no counter is built; dcache has strict priority and icache may starve indefinitely.

## Test plan
- Reset with iREN=1, dREN=1 held -> all outputs at reset values; the first grant after release is DGRANT.
- dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ramstate=ACCESS immediately -> ramWEN=1 and ramaddr=0x100 in cycle 1, dwait=0 for exactly one cycle, then IDLE.
- iREN=1, iaddr=0x40; ramstate BUSY for 3 cycles then ACCESS with ramload=0x12345678 -> iwait=0 only in the ACCESS cycle, with iload=0x12345678.
- iREN and dREN held high continuously, zero-latency RAM -> without the guard, the icache is never granted over 20 accesses. With ARB_STARVE_GUARD_EN and STARVE_MAX=4, grants follow the pattern D,D,D,D,I repeating.
- ramstate=ERROR for 2 cycles during DGRANT, then ACCESS -> ram_err=1 and sticky, dwait stays 1 until ACCESS, then the access completes normally.
- dREN deasserted during DGRANT with ramstate=BUSY -> ramREN=0 that cycle, no dwait pulse, IDLE next cycle.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: requestor and RAM signals of the cache/memory arbiter.
// The arbiter uses the slave modport; caches and RAM model use master.
interface cache_mem_arbiter_if #(parameter int RAM_W = 32);
    logic             iREN;
    logic [RAM_W-1:0] iaddr;
    logic             iwait;
    logic [RAM_W-1:0] iload;
    logic             dREN;
    logic             dWEN;
    logic [RAM_W-1:0] daddr;
    logic [RAM_W-1:0] dstore;
    logic             dwait;
    logic [RAM_W-1:0] dload;
    logic             ramREN;
    logic             ramWEN;
    logic [RAM_W-1:0] ramaddr;
    logic [RAM_W-1:0] ramstore;
    logic [RAM_W-1:0] ramload;
    logic [1:0]       ramstate;
    logic             ram_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serialises icache/dcache word accesses onto one RAM port, dcache first.
// Define ARB_STARVE_GUARD_EN to build the dstreak counter that forces an icache grant.
module cache_mem_arbiter #(
`ifdef ARB_STARVE_GUARD_EN
    parameter int STARVE_MAX = 4,
`endif
    parameter int RAM_W = 32
) (
    input logic                CLK,
    input logic                nRST,
    cache_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    state_t state, next_state;
    logic   dreq, done, force_i, err_q;

    assign dreq = bus.dREN | bus.dWEN;
    assign done = bus.ramstate == ACCESS;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] dstreak;
    assign force_i = dstreak == 4'(STARVE_MAX);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dstreak <= '0;
        end else if (state == IDLE) begin
            if (!bus.iREN || next_state == IGRANT)
                dstreak <= '0;
            else if (next_state == DGRANT && !force_i)
                dstreak <= dstreak + 4'd1;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state != IDLE && bus.ramstate == ERROR)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        bus.ramWEN   = state == DGRANT && bus.dWEN;
        bus.ramREN   = (state == DGRANT && bus.dREN && !bus.dWEN) || (state == IGRANT && bus.iREN);
        bus.ramaddr  = state == DGRANT ? bus.daddr : state == IGRANT ? bus.iaddr : '0;
        bus.ramstore = bus.ramWEN ? bus.dstore : '0;
        bus.dwait    = !(state == DGRANT && dreq && done);
        bus.iwait    = !(state == IGRANT && bus.iREN && done);
        // a dropped request or a completed access both hand the port back
        next_state   = state == IDLE
                     ? (dreq && !(bus.iREN && force_i) ? DGRANT : bus.iREN ? IGRANT : IDLE)
                     : (!bus.dwait || !bus.iwait || (state == DGRANT && !dreq) ||
                        (state == IGRANT && !bus.iREN)) ? IDLE : state;
    end

    assign bus.iload   = bus.ramload;
    assign bus.dload   = bus.ramload;
    assign bus.ram_err = err_q;
endmodule
